pipe_adder: RTL and testbench

//   Parametrised, pipelined ripple-by-chunk adder/subtractor. Successor to the fixed 8-bit combinational adder.

---
 rtl/pipe_adder_pkg.sv | 17 +
 rtl/pipe_adder_stage.sv | 74 +++++++
 rtl/pipe_adder.sv | 81 ++++++++
 tb/tb_pipe_adder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_adder_pkg                                                  |
// | Brief    : Shared defaults and slice-width helper for the pipelined adder. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pipe_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_adder_stage                                                |
// | Brief    : One CHUNK-bit slice adder with its stage register.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int CHUNK = chunk_w(DEFAULT_WIDTH, DEFAULT_STAGES),
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_acc,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_acc,
  output logic [WIDTH-1:0] out_b,
  output logic             out_carry,
  output logic             out_ovf
);

  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] slice_ext;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] acc_d, acc_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;

  // acc holds the unconsumed A slices in its low bits and the finished sum
  // slices in its high bits; after the last stage it is exactly the sum.
  always_comb begin
    slice_sum = {1'b0, in_acc[CHUNK-1:0]} + {1'b0, in_b[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, in_carry};
    slice_ext = WIDTH'(slice_sum[CHUNK-1:0]);
    valid_d   = in_valid;
    acc_d     = (in_acc >> CHUNK) | (slice_ext << (WIDTH - CHUNK));
    b_d       = in_b >> CHUNK;
    carry_d   = slice_sum[CHUNK];
    // Only meaningful in the last stage, where this slice holds both MSBs.
    ovf_d     = (in_acc[CHUNK-1] == in_b[CHUNK-1]) &&
                (slice_sum[CHUNK-1] != in_acc[CHUNK-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (en) begin
      valid_q <= valid_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_acc   = acc_q;
  assign out_b     = b_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_adder                                                      |
// | Brief    : Pipelined chunked adder/subtractor with valid/ready streaming.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic                       en;
  logic [STAGES:0]            v_p;
  logic [STAGES:0]            c_p;
  logic [STAGES:0][WIDTH-1:0] acc_p;
  logic [STAGES:0][WIDTH-1:0] b_p;
  logic [STAGES:1]            ovf_p;
  logic                       unused_tail;

  // Single global enable: the whole pipe advances only when the output
  // register is empty or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign v_p[0]   = in_valid && in_ready;
  assign acc_p[0] = a;
  assign b_p[0]   = sub ? ~b : b;
  assign c_p[0]   = sub ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(
      .CHUNK (CHUNK),
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_p[k]),
      .in_acc    (acc_p[k]),
      .in_b      (b_p[k]),
      .in_carry  (c_p[k]),
      .out_valid (v_p[k+1]),
      .out_acc   (acc_p[k+1]),
      .out_b     (b_p[k+1]),
      .out_carry (c_p[k+1]),
      .out_ovf   (ovf_p[k+1])
    );
  end

  assign out_valid = v_p[STAGES];
  assign sum       = acc_p[STAGES];
  assign cout      = c_p[STAGES];
  assign ovf       = ovf_p[STAGES];

  // B is fully consumed by the last stage and only the last ovf is used.
  assign unused_tail = ^{b_p[STAGES], ovf_p};

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_adder                                                   |
// | Brief    : Scoreboard bench for pipe_adder in 8/2, 32/4 and 8/1 configs.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pipe_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        s;
    logic [31:0] sum;
    logic        co;
    logic        of;
  } vec_t;

  localparam int CW [3] = '{8, 32, 8};
  localparam int CS [3] = '{2, 4, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        cin_in = 1'b0;
  logic        sub_in = 1'b0;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        co   [3];
  logic        of   [3];
  logic [31:0] sw   [3];
  logic [7:0]  sum0;
  logic [31:0] sum1;
  logic [7:0]  sum2;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  vec_t t8  [8];
  vec_t t32 [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0), .cout(co[0]), .ovf(of[0])
  );

  pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1), .cout(co[1]), .ovf(of[1])
  );

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum2), .cout(co[2]), .ovf(of[2])
  );

  assign sw[0] = {24'h0, sum0};
  assign sw[1] = sum1;
  assign sw[2] = {24'h0, sum2};

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic int qsize(input int c);
    case (c)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int c, input exp_t e);
    case (c)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int c, output exp_t e);
    case (c)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Independent arithmetic reference: plain integer add/subtract and a range test.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic s);
    exp_t   e;
    longint m, ua, ub, sa, sb, r, sr, hi, lo;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (m + 1) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (m + 1) : ub;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (!s) begin
      r      = ua + ub + longint'(ci);
      e.cout = (((r >> w) & 1) != 0);
      sr     = sa + sb + longint'(ci);
    end else begin
      r      = ua - ub;
      e.cout = (ua >= ub);
      sr     = sa - sb;
    end
    e.sum = 32'(r & m);
    e.ovf = (sr > hi) || (sr < lo);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input int c, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic s, input exp_t e);
    int waitc = 0;
    a_in = a; b_in = b; cin_in = ci; sub_in = s; iv[c] = 1'b1;
    #1;
    while (!ir[c] && waitc < 50) begin
      @(negedge clk); #1; waitc++;
    end
    if (!ir[c]) begin
      check(1'b0, $sformatf("cfg%0d in_ready_timeout", c), 64'(ir[c]), 64'd1);
      iv[c] = 1'b0;
      @(negedge clk);
    end else begin
      e.cyc = cyc + CS[c];
      qpush(c, e);
      @(negedge clk);
      iv[c] = 1'b0;
    end
  endtask

  task automatic drain(input int c);
    int n = 0;
    while (qsize(c) != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check(qsize(c) == 0, $sformatf("cfg%0d drain_pending", c), 64'(qsize(c)), 64'd0);
  endtask

  task automatic stream(input int c);
    int   sent = 0;
    int   n    = 0;
    exp_t e;
    logic [31:0] ra, rb;
    logic rc, rs;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    while (sent < 16 && n < 300) begin
      ordy[c] = ($urandom_range(0, 3) != 0);
      a_in = ra; b_in = rb; cin_in = rc; sub_in = rs; iv[c] = 1'b1;
      #1;
      if (ir[c]) begin
        e = model(CW[c], ra, rb, rc, rs);
        qpush(c, e);
        sent++;
        ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    iv[c]   = 1'b0;
    ordy[c] = 1'b1;
    check(sent == 16, $sformatf("cfg%0d stream_sent", c), 64'(sent), 64'd16);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold while stalled.
  logic [31:0] h_sum [3];
  logic        h_co  [3];
  logic        h_of  [3];
  bit          h_v   [3];
  exp_t        mon_e;

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (!rst && h_v[i])
        check(ov[i] === 1'b1 && sw[i] === h_sum[i] && co[i] === h_co[i] && of[i] === h_of[i],
              $sformatf("cfg%0d stall_hold", i),
              {30'h0, co[i], of[i], sw[i]}, {30'h0, h_co[i], h_of[i], h_sum[i]});
      if (!rst && ov[i] === 1'b1 && ordy[i]) begin
        if (qsize(i) == 0) begin
          check(1'b0, $sformatf("cfg%0d unexpected_output", i), {30'h0, co[i], of[i], sw[i]}, 64'd0);
        end else begin
          qpop(i, mon_e);
          check(sw[i] === mon_e.sum && co[i] === mon_e.cout && of[i] === mon_e.ovf,
                $sformatf("cfg%0d result{cout,ovf,sum}", i),
                {30'h0, co[i], of[i], sw[i]}, {30'h0, mon_e.cout, mon_e.ovf, mon_e.sum});
          if (mon_e.lat)
            check(cyc == mon_e.cyc, $sformatf("cfg%0d latency_cycle", i), 64'(cyc), 64'(mon_e.cyc));
        end
      end
      h_v[i]   = !rst && ov[i] === 1'b1 && !ordy[i];
      h_sum[i] = sw[i];
      h_co[i]  = co[i];
      h_of[i]  = of[i];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1; h_v[i] = 1'b0;
    end
    t8 = '{
      '{32'h05, 32'h03, 1'b0, 1'b0, 32'h08, 1'b0, 1'b0},
      '{32'hAA, 32'h55, 1'b0, 1'b0, 32'hFF, 1'b0, 1'b0},
      '{32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0},
      '{32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1},
      '{32'h0F, 32'h00, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0},
      '{32'h10, 32'h20, 1'b0, 1'b1, 32'hF0, 1'b0, 1'b0},
      '{32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1},
      '{32'h20, 32'h10, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0}
    };
    t32 = '{
      '{32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0},
      '{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0},
      '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
      '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0},
      '{32'h00000010, 32'h00000020, 1'b0, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0},
      '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
      '{32'h00000020, 32'h00000010, 1'b1, 1'b1, 32'h00000010, 1'b1, 1'b0}
    };

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    for (int c = 0; c < 3; c++)
      check(ov[c] === 1'b0 && sw[c] === 32'h0 && co[c] === 1'b0 && of[c] === 1'b0 && ir[c] === 1'b1,
            $sformatf("cfg%0d reset_state{ir,ov,cout,ovf,sum}", c),
            {28'h0, ir[c], ov[c], co[c], of[c], sw[c]}, {28'h0, 4'b1000, 32'h0});
    @(negedge clk);

    for (int c = 0; c < 3; c++) begin
      for (int v = 0; v < 8; v++) begin
        vec_t t;
        t = (c == 1) ? t32[v] : t8[v];
        e.sum = t.sum; e.cout = t.co; e.ovf = t.of; e.cyc = 0; e.lat = 1'b1;
        send(c, t.a, t.b, t.ci, t.s, e);
      end
      drain(c);
      stream(c);
      drain(c);
    end

    // Reset with two beats in flight on the 8-bit, 2-stage instance.
    ordy[0] = 1'b0;
    a_in = 32'h11; b_in = 32'h22; cin_in = 1'b0; sub_in = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    a_in = 32'h33; b_in = 32'h44;
    @(negedge clk);
    a_in = 32'h55; b_in = 32'h66;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check(ov[0] === 1'b0, "cfg0 rst_flush_out_valid", 64'(ov[0]), 64'd0);
    rst = 1'b0;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check(ov[0] === 1'b0, "cfg0 no_partial_after_rst", 64'(ov[0]), 64'd0);
    @(negedge clk);
    e.sum = 32'h02; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = 0; e.lat = 1'b1;
    send(0, 32'h01, 32'h01, 1'b0, 1'b0, e);
    drain(0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
